f1_lights_seq: RTL and testbench
================================

// Module: f1_lights_seq
// PURPOSE
//  Parametrised start-light sequencer for the reaction-timer datapath. On trigger it fills
//  N_LIGHTS LEDs one per step tick (thermometer code), then holds all-on and requests the
//  random delay. Delay timeout returns it to idle. It gates the LFSR and arms the reaction
//  counter. Sits between the tick/prescaler blocks and the LFSR/delay/reaction-counter blocks.
// PARAMETERS
//  N_LIGHTS  10  number of lights driven; legal range 2..32
//  FILL_DIR  0   0: fill from bit 0 upward; 1: fill from bit N_LIGHTS-1 downward
// PORTS
//  clk             in   1         system clock (ms tick domain)
//  rst             in   1         asynchronous, active-high reset
//  tick            in   1         single-cycle step strobe (e.g. 0.5 s)
//  trigger         in   1         start request, level (inverted key)
//  time_out        in   1         single-cycle pulse from random delay block
//  en_lfsr         out  1         LFSR run enable
//  start_delay     out  1         level: delay block counts while high
//  ledr            out  N_LIGHTS  light outputs
//  reactiontrigger out  1         high while idle: reaction counter may stop/restart
//  lit_cnt         out  CW        lights currently lit; CW = $clog2(N_LIGHTS+1)
//  jump_start      out  1         early-press flag (0 unless JUMP_START_DET_EN)
// BEHAVIOUR
//  - Reset: rst is asynchronous and active-high; clock is clk. Reset forces state=IDLE,
//    lit_cnt=0, trig_q=0, ledr=0, en_lfsr=1, start_delay=0, reactiontrigger=1, jump_start=0.
//  - State and lit_cnt are registered on posedge clk. Outputs are Moore-decoded from
//    {state, lit_cnt} with no extra latency.
//  - IDLE: ledr=0, en_lfsr=1, start_delay=0, reactiontrigger=1.
//    If trigger=1, go to FILL with lit_cnt=0. tick is ignored in IDLE, including on the
//    same cycle as trigger.
//  - FILL: reactiontrigger=0, start_delay=0.
//    ledr holds lit_cnt ones: FILL_DIR=0 gives (1<<lit_cnt)-1; FILL_DIR=1 gives the bit-reversed value.
//    en_lfsr=1 while lit_cnt<N_LIGHTS-1; en_lfsr=0 when lit_cnt==N_LIGHTS-1, which freezes the
//    LFSR seed before the delay starts.
//    On tick with lit_cnt<N_LIGHTS-1: lit_cnt+1.
//    On tick with lit_cnt==N_LIGHTS-1: go to HOLD with lit_cnt=N_LIGHTS.
//    Filling therefore takes N_LIGHTS ticks after trigger.
//  - HOLD: ledr all ones, en_lfsr=0, start_delay=1, reactiontrigger=0.
//    On time_out go to IDLE with lit_cnt=0; ledr clears on the next clk edge.
//  - time_out outside HOLD is ignored. trigger outside IDLE is ignored (level or edge), unless
//    JUMP_START_DET_EN is defined.
//  - lit_cnt never exceeds N_LIGHTS and never wraps.
//  - Unreachable state encodings recover to IDLE on the next clk.
//  - rst asserted mid-sequence aborts immediately to the reset values; no pending tick is remembered.
// CONFIGURATION
//  JUMP_START_DET_EN defined:
//    - trig_q registers trigger each clk.
//    - A rising edge (trigger & ~trig_q) while in FILL with lit_cnt>=1, or while in HOLD,
//      goes to ABORT.
//    - ABORT: jump_start=1, start_delay=0, en_lfsr=1, reactiontrigger=0. ledr toggles between
//      all-ones and all-zeros on each tick, entering with all-ones.
//    - ABORT exits to IDLE on the first tick with trigger=0; jump_start clears with it.
//    - time_out is ignored in ABORT.
//    - A held key from the start press is not a rising edge and does not abort.
//  JUMP_START_DET_EN undefined: no ABORT state, no trig_q; jump_start tied 0.
// TESTING
//  1 rst pulse mid-FILL (lit_cnt=5) -> next cycle ledr=0, lit_cnt=0, reactiontrigger=1, en_lfsr=1.
//  2 N=10, FILL_DIR=0: trigger 1 cycle, then 10 ticks -> ledr 0x000,0x001,0x003..0x1FF,0x3FF;
//    en_lfsr drops when ledr=0x1FF; start_delay=1 at 0x3FF.
//  3 In HOLD, time_out pulse -> IDLE next cycle, ledr=0, reactiontrigger=1.
//    time_out pulses during FILL -> no effect.
//  4 N=4, FILL_DIR=1: 4 ticks -> ledr 0x0,0x8,0xC,0xE,0xF.
//    trigger+tick on the same cycle in IDLE -> lit_cnt=0.
//  5 JUMP_START_DET_EN: start press held 3 ticks -> no abort.
//    Release, then re-press at lit_cnt=3 -> jump_start=1, ledr=0x3FF, then 0x000 on the next tick.
//    Release, then tick -> IDLE.
//  6 Macro undefined: re-press during FILL/HOLD -> sequence unaffected, jump_start=0 throughout.

Source files
------------

// File: rtl/f1_lights_seq.sv
// Start-light sequencer: fills N_LIGHTS lights one per tick, holds them all on while the
// random delay runs, then returns to idle. Optional jump-start detection: JUMP_START_DET_EN.
module f1_lights_seq #(
  parameter int N_LIGHTS = 10,
  parameter int FILL_DIR = 0,
  localparam int CW = $clog2(N_LIGHTS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick,
  input  logic                trigger,
  input  logic                time_out,
  output logic                en_lfsr,
  output logic                start_delay,
  output logic [N_LIGHTS-1:0] ledr,
  output logic                reactiontrigger,
  output logic [CW-1:0]       lit_cnt,
  output logic                jump_start
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_HOLD  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  localparam logic [CW-1:0] LAST = CW'(N_LIGHTS - 1);
  localparam logic [CW-1:0] FULL = CW'(N_LIGHTS);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt_n;
  logic          blink;
  logic          blink_n;
  logic          rise;

  // Thermometer pattern with n lights on, filled from the configured end.
  function automatic logic [N_LIGHTS-1:0] therm(input logic [CW-1:0] n);
    logic [N_LIGHTS-1:0] v;
    v = '0;
    for (int i = 0; i < N_LIGHTS; i++) begin
      if (FILL_DIR == 0) begin
        v[i] = (i < int'(n));
      end else begin
        v[N_LIGHTS-1-i] = (i < int'(n));
      end
    end
    return v;
  endfunction

`ifdef JUMP_START_DET_EN
  logic trig_q;

  // A key still held from the start press never counts as a new press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trigger;
    end
  end

  assign rise = trigger & ~trig_q;
`else
  assign rise = 1'b0;
`endif

  // Next-state and next-count logic.
  always_comb begin
    state_n = state;
    cnt_n   = lit_cnt;
    blink_n = blink;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (trigger) begin
          state_n = S_FILL;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_FILL: begin
        if (rise && (lit_cnt >= CW'(1))) begin
          state_n = S_ABORT;
          blink_n = 1'b1;
        end else if (tick) begin
          if (lit_cnt < LAST) begin
            cnt_n = lit_cnt + CW'(1);
          end else begin
            state_n = S_HOLD;
            cnt_n   = FULL;
          end
        end else begin
          state_n = S_FILL;
        end
      end
      S_HOLD: begin
        if (rise) begin
          state_n = S_ABORT;
          blink_n = 1'b1;
        end else if (time_out) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          state_n = S_HOLD;
        end
      end
`ifdef JUMP_START_DET_EN
      S_ABORT: begin
        if (tick) begin
          if (!trigger) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            blink_n = 1'b0;
          end else begin
            blink_n = ~blink;
          end
        end else begin
          state_n = S_ABORT;
        end
      end
`endif
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        blink_n = 1'b0;
      end
    endcase
  end

  // State register; outputs are decoded from the next state so they track it without lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      lit_cnt         <= '0;
      blink           <= 1'b0;
      ledr            <= '0;
      en_lfsr         <= 1'b1;
      start_delay     <= 1'b0;
      reactiontrigger <= 1'b1;
      jump_start      <= 1'b0;
    end else begin
      state   <= state_n;
      lit_cnt <= cnt_n;
      blink   <= blink_n;
      case (state_n)
        S_IDLE: begin
          ledr            <= '0;
          en_lfsr         <= 1'b1;
          start_delay     <= 1'b0;
          reactiontrigger <= 1'b1;
          jump_start      <= 1'b0;
        end
        S_FILL: begin
          ledr            <= therm(cnt_n);
          en_lfsr         <= (cnt_n < LAST);
          start_delay     <= 1'b0;
          reactiontrigger <= 1'b0;
          jump_start      <= 1'b0;
        end
        S_HOLD: begin
          ledr            <= '1;
          en_lfsr         <= 1'b0;
          start_delay     <= 1'b1;
          reactiontrigger <= 1'b0;
          jump_start      <= 1'b0;
        end
        S_ABORT: begin
          ledr            <= blink_n ? '1 : '0;
          en_lfsr         <= 1'b1;
          start_delay     <= 1'b0;
          reactiontrigger <= 1'b0;
          jump_start      <= 1'b1;
        end
        default: begin
          ledr            <= '0;
          en_lfsr         <= 1'b1;
          start_delay     <= 1'b0;
          reactiontrigger <= 1'b1;
          jump_start      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_f1_lights_seq.sv
// Self-checking bench for f1_lights_seq: a 10-light upward and a 4-light downward instance
// share stimulus and are compared against a behavioural light-sequence model.
module tb_f1_lights_seq;

`ifdef JUMP_START_DET_EN
  localparam bit JSE = 1'b1;
`else
  localparam bit JSE = 1'b0;
`endif
  localparam int M_IDLE = 0, M_FILL = 1, M_HOLD = 2, M_ABORT = 3;

  logic clk = 1'b0, rst = 1'b1, tick = 1'b0, trigger = 1'b0, time_out = 1'b0;
  logic en_a, sd_a, rt_a, js_a, en_b, sd_b, rt_b, js_b;
  logic [9:0] ledr_a;
  logic [3:0] cnt_a;
  logic [3:0] ledr_b;
  logic [2:0] cnt_b;

  int checks = 0, failures = 0;
  int nl[2] = '{10, 4};
  int dir[2] = '{0, 1};
  int m_mode[2], m_lit[2];
  bit m_tq[2], m_blink[2];

  always #5 clk = ~clk;

  f1_lights_seq #(.N_LIGHTS(10), .FILL_DIR(0)) dut_a (
    .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .time_out(time_out),
    .en_lfsr(en_a), .start_delay(sd_a), .ledr(ledr_a), .reactiontrigger(rt_a),
    .lit_cnt(cnt_a), .jump_start(js_a));

  f1_lights_seq #(.N_LIGHTS(4), .FILL_DIR(1)) dut_b (
    .clk(clk), .rst(rst), .tick(tick), .trigger(trigger), .time_out(time_out),
    .en_lfsr(en_b), .start_delay(sd_b), .ledr(ledr_b), .reactiontrigger(rt_b),
    .lit_cnt(cnt_b), .jump_start(js_b));

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = M_IDLE; m_lit[k] = 0; m_tq[k] = 1'b0; m_blink[k] = 1'b0;
    end
  endtask

  task automatic model_step(int k);
    bit rise;
    rise = JSE && trigger && !m_tq[k];
    case (m_mode[k])
      M_IDLE: if (trigger) begin m_mode[k] = M_FILL; m_lit[k] = 0; end
      M_FILL:
        if (rise && m_lit[k] >= 1) begin m_mode[k] = M_ABORT; m_blink[k] = 1'b1; end
        else if (tick) begin
          if (m_lit[k] < nl[k] - 1) m_lit[k]++;
          else begin m_mode[k] = M_HOLD; m_lit[k] = nl[k]; end
        end
      M_HOLD:
        if (rise) begin m_mode[k] = M_ABORT; m_blink[k] = 1'b1; end
        else if (time_out) begin m_mode[k] = M_IDLE; m_lit[k] = 0; end
      default:
        if (tick) begin
          if (!trigger) begin m_mode[k] = M_IDLE; m_lit[k] = 0; end
          else m_blink[k] = !m_blink[k];
        end
    endcase
    m_tq[k] = trigger;
  endtask

  function automatic logic [31:0] exp_ledr(int k);
    logic [31:0] mask, t;
    mask = (32'd1 << nl[k]) - 32'd1;
    if (m_mode[k] == M_IDLE) return 32'd0;
    if (m_mode[k] == M_ABORT) return m_blink[k] ? mask : 32'd0;
    t = (32'd1 << m_lit[k]) - 32'd1;
    if (dir[k] == 1) t = t << (nl[k] - m_lit[k]);
    return t & mask;
  endfunction

  function automatic logic exp_en(int k);
    return (m_mode[k] == M_IDLE) || (m_mode[k] == M_ABORT) ||
           (m_mode[k] == M_FILL && m_lit[k] < nl[k] - 1);
  endfunction

  // One clock: inputs are already stable, model advances, outputs sampled 1 ns after the edge.
  task automatic cyc();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    trigger = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (m_mode[0] == M_IDLE && m_mode[1] == M_IDLE) break;
      tick = 1'b1; time_out = 1'b1;
      cyc();
    end
    tick = 1'b0; time_out = 1'b0;
    cyc();
    checks++;
    if (rt_a !== 1'b1 || rt_b !== 1'b1 || ledr_a !== 10'h000) begin
      failures++;
      $display("FAIL go_idle rt_a=%b rt_b=%b ledr_a=%h required rt=1 ledr=000", rt_a, rt_b, ledr_a);
    end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ledr_a, cnt_a, en_a, sd_a, rt_a, js_a} !== {10'h000, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reset_a ledr=%h cnt=%0d en=%b sd=%b rt=%b js=%b required 000 0 1 0 1 0",
               ledr_a, cnt_a, en_a, sd_a, rt_a, js_a);
    end
    checks++;
    if ({ledr_b, cnt_b, en_b, rt_b} !== {4'h0, 3'd0, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL reset_b ledr=%h cnt=%0d en=%b rt=%b required 0 0 1 1", ledr_b, cnt_b, en_b, rt_b);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_fill();
    logic [9:0] want;
    trigger = 1'b1; cyc(); trigger = 1'b0;
    checks++;
    if (ledr_a !== 10'h000 || rt_a !== 1'b0 || en_a !== 1'b1 || cnt_a !== 4'd0) begin
      failures++;
      $display("FAIL fill_start ledr=%h rt=%b en=%b cnt=%0d required 000 0 1 0", ledr_a, rt_a, en_a, cnt_a);
    end
    for (int i = 1; i <= 10; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      want = (i == 10) ? 10'h3FF : 10'((1 << i) - 1);
      checks++;
      if (ledr_a !== want || en_a !== (i < 9) || sd_a !== (i == 10)) begin
        failures++;
        $display("FAIL fill_step i=%0d ledr=%h en=%b sd=%b required %h %b %b",
                 i, ledr_a, en_a, sd_a, want, i < 9, i == 10);
      end
      checks++;
      if (ledr_b !== exp_ledr(1)) begin
        failures++;
        $display("FAIL fill_b i=%0d ledr=%h required %h", i, ledr_b, exp_ledr(1));
      end
    end
  endtask

  task automatic test_timeout();
    time_out = 1'b1; cyc(); time_out = 1'b0;
    checks++;
    if (ledr_a !== 10'h000 || rt_a !== 1'b1 || sd_a !== 1'b0 || cnt_a !== 4'd0) begin
      failures++;
      $display("FAIL hold_exit ledr=%h rt=%b sd=%b cnt=%0d required 000 1 0 0", ledr_a, rt_a, sd_a, cnt_a);
    end
    trigger = 1'b1; cyc(); trigger = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      time_out = 1'b1; cyc(); time_out = 1'b0;
    end
    checks++;
    if (ledr_a !== 10'h003 || cnt_a !== 4'd2 || rt_a !== 1'b0) begin
      failures++;
      $display("FAIL fill_timeout ledr=%h cnt=%0d rt=%b required 003 2 0", ledr_a, cnt_a, rt_a);
    end
    go_idle();
  endtask

  task automatic test_dir();
    logic [3:0] seq [4] = '{4'h8, 4'hC, 4'hE, 4'hF};
    trigger = 1'b1; tick = 1'b1; cyc(); trigger = 1'b0; tick = 1'b0;
    checks++;
    if (cnt_b !== 3'd0 || ledr_b !== 4'h0 || cnt_a !== 4'd0) begin
      failures++;
      $display("FAIL trig_tick cnt_b=%0d ledr_b=%h cnt_a=%0d required 0 0 0", cnt_b, ledr_b, cnt_a);
    end
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      checks++;
      if (ledr_b !== seq[i]) begin
        failures++;
        $display("FAIL dir_fill i=%0d ledr_b=%h required %h", i, ledr_b, seq[i]);
      end
    end
    checks++;
    if (sd_b !== 1'b1 || cnt_b !== 3'd4 || en_b !== 1'b0) begin
      failures++;
      $display("FAIL dir_hold sd=%b cnt=%0d en=%b required 1 4 0", sd_b, cnt_b, en_b);
    end
    go_idle();
  endtask

  task automatic test_jump();
    trigger = 1'b1; cyc();
    for (int i = 0; i < 3; i++) begin tick = 1'b1; cyc(); tick = 1'b0; cyc(); end
    checks++;
    if (js_a !== 1'b0 || cnt_a !== 4'd3 || ledr_a !== 10'h007) begin
      failures++;
      $display("FAIL held_key js=%b cnt=%0d ledr=%h required 0 3 007", js_a, cnt_a, ledr_a);
    end
    trigger = 1'b0; cyc();
    trigger = 1'b1; cyc();
`ifdef JUMP_START_DET_EN
    checks++;
    if (js_a !== 1'b1 || ledr_a !== 10'h3FF || sd_a !== 1'b0 || en_a !== 1'b1) begin
      failures++;
      $display("FAIL abort_enter js=%b ledr=%h sd=%b en=%b required 1 3ff 0 1", js_a, ledr_a, sd_a, en_a);
    end
    tick = 1'b1; cyc(); tick = 1'b0;
    checks++;
    if (ledr_a !== 10'h000 || js_a !== 1'b1) begin
      failures++;
      $display("FAIL abort_blink ledr=%h js=%b required 000 1", ledr_a, js_a);
    end
    trigger = 1'b0; cyc();
    tick = 1'b1; cyc(); tick = 1'b0;
    checks++;
    if (rt_a !== 1'b1 || js_a !== 1'b0 || ledr_a !== 10'h000) begin
      failures++;
      $display("FAIL abort_exit rt=%b js=%b ledr=%h required 1 0 000", rt_a, js_a, ledr_a);
    end
`else
    checks++;
    if (js_a !== 1'b0 || ledr_a !== 10'h007 || cnt_a !== 4'd3) begin
      failures++;
      $display("FAIL repress js=%b ledr=%h cnt=%0d required 0 007 3", js_a, ledr_a, cnt_a);
    end
    tick = 1'b1; cyc(); tick = 1'b0;
    checks++;
    if (ledr_a !== 10'h00F || js_b !== 1'b0 || sd_b !== 1'b1) begin
      failures++;
      $display("FAIL repress_go ledr_a=%h js_b=%b sd_b=%b required 00f 0 1", ledr_a, js_b, sd_b);
    end
`endif
    go_idle();
  endtask

  task automatic test_rst_mid();
    trigger = 1'b1; cyc(); trigger = 1'b0;
    for (int i = 0; i < 5; i++) begin tick = 1'b1; cyc(); tick = 1'b0; end
    checks++;
    if (cnt_a !== 4'd5) begin
      failures++;
      $display("FAIL pre_rst cnt=%0d required 5", cnt_a);
    end
    tick = 1'b1;
    #1 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (ledr_a !== 10'h000 || cnt_a !== 4'd0 || rt_a !== 1'b1 || en_a !== 1'b1 || ledr_b !== 4'h0) begin
      failures++;
      $display("FAIL rst_mid ledr=%h cnt=%0d rt=%b en=%b ledr_b=%h required 000 0 1 1 0",
               ledr_a, cnt_a, rt_a, en_a, ledr_b);
    end
    tick = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (cnt_a !== 4'd0 || rt_a !== 1'b1) begin
      failures++;
      $display("FAIL post_rst cnt=%0d rt=%b required 0 1", cnt_a, rt_a);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(7) == 0) trigger = ~trigger;
      tick = ($urandom_range(2) == 0);
      time_out = ($urandom_range(5) == 0);
      cyc();
      for (int k = 0; k < 2; k++) begin
        logic [31:0] al;
        int ac;
        logic ae, as, ar, aj;
        if (k == 0) begin al = {22'd0, ledr_a}; ac = int'(cnt_a); ae = en_a; as = sd_a; ar = rt_a; aj = js_a; end
        else begin al = {28'd0, ledr_b}; ac = int'(cnt_b); ae = en_b; as = sd_b; ar = rt_b; aj = js_b; end
        checks++;
        if (al !== exp_ledr(k) || ac != m_lit[k]) begin
          failures++;
          $display("FAIL rand_ledr dut=%0d cyc=%0d ledr=%h cnt=%0d required %h %0d", k, c, al, ac, exp_ledr(k), m_lit[k]);
        end
        checks++;
        if (ae !== exp_en(k) || as !== (m_mode[k] == M_HOLD) || ar !== (m_mode[k] == M_IDLE) ||
            aj !== (m_mode[k] == M_ABORT)) begin
          failures++;
          $display("FAIL rand_ctl dut=%0d cyc=%0d en/sd/rt/js=%b%b%b%b required %b%b%b%b", k, c, ae, as, ar, aj,
                   exp_en(k), m_mode[k] == M_HOLD, m_mode[k] == M_IDLE, m_mode[k] == M_ABORT);
        end
      end
    end
    tick = 1'b0; time_out = 1'b0;
    go_idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_timeout();
    test_dir();
    test_jump();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
